// File: rtl/pci_arbiter_pkg.sv
// Shared definitions for the PCI central arbiter and its bus peers.
// Arbiter state encodings and bus command codes live here once.
package pci_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_DEAD  = 2'd0,
    ST_PARK  = 2'd1,
    ST_GRANT = 2'd2,
    ST_BUSY  = 2'd3
  } arb_state_t;

  localparam logic [3:0] MEM_READ        = 4'b0110;
  localparam logic [3:0] MEM_WRITE       = 4'b0111;
  localparam logic [3:0] MEM_READ_MUL    = 4'b1100;
  localparam logic [3:0] MEM_READ_LINE   = 4'b1110;
  localparam logic [3:0] MEM_WRITE_INVAL = 4'b1111;

endpackage

// File: rtl/pci_arbiter_rr_picker.sv
// Round-robin winner select: first requester after the last owner,
// with the last owner itself considered last.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any_req
);

  int         idx;
  logic [W-1:0] k;

  assign any_req = |req;

  // scan from farthest to nearest so the nearest requester wins
  always_comb begin
    winner = last;
    idx    = 0;
    k      = '0;
    for (int i = N; i >= 1; i--) begin
      idx = (int'(last) + i) % N;
      k   = W'(idx);
      if (req[k]) winner = k;
    end
  end

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI arbiter: round-robin grant with parking, hidden
// arbitration and a grant-ignored timeout.
module pci_arbiter #(
  parameter int N_MASTERS   = 4,
  parameter int PARK_MASTER = 0,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         FRAME,
  input  logic                         IRDY,
  input  logic [N_MASTERS-1:0]         REQ,
  output logic [N_MASTERS-1:0]         GNT,
  output logic [$clog2(N_MASTERS)-1:0] OWNER,
  output logic                         BUS_BUSY
);
  import pci_arbiter_pkg::*;

  localparam int W  = $clog2(N_MASTERS);
  localparam int TW = $clog2(GNT_TIMEOUT + 1);
  localparam logic [W-1:0]  PARK = W'(PARK_MASTER);
  localparam logic [W-1:0]  LAST = W'(N_MASTERS - 1);
  localparam logic [TW-1:0] TMAX = TW'(GNT_TIMEOUT - 1);

  arb_state_t state, state_d;
  logic [W-1:0]  grantee, grantee_d;
  logic [W-1:0]  owner_d, winner;
  logic [TW-1:0] timer, timer_d;
  logic          rel, rel_d;
  logic [N_MASTERS-1:0] gnt_d, req;
  logic          any_req, idle, expired;

  function automatic logic others(
    input logic [N_MASTERS-1:0] r,
    input logic [W-1:0]         m
  );
    logic [N_MASTERS-1:0] mask;
    mask = N_MASTERS'(1) << m;
    return |(r & ~mask);
  endfunction

  assign req     = ~REQ;
  assign idle    = FRAME & IRDY;
  assign expired = idle && (timer == TMAX);

  rr_picker #(.N(N_MASTERS), .W(W)) u_pick (
    .req     (req),
    .last    (OWNER),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_DEAD;
      OWNER    <= LAST;
      grantee  <= LAST;
      timer    <= '0;
      rel      <= 1'b0;
      GNT      <= '1;
      BUS_BUSY <= 1'b0;
    end else begin
      state    <= state_d;
      OWNER    <= owner_d;
      grantee  <= grantee_d;
      timer    <= timer_d;
      rel      <= rel_d;
      GNT      <= gnt_d;
      BUS_BUSY <= ~FRAME | ~IRDY;
    end
  end

  always_comb begin
    state_d   = state;
    owner_d   = OWNER;
    grantee_d = grantee;
    timer_d   = '0;
    rel_d     = 1'b0;
    unique case (state)
      ST_DEAD: begin
        if (any_req) begin
          state_d   = ST_GRANT;
          grantee_d = winner;
        end else begin
          state_d = ST_PARK;
        end
      end
      ST_PARK: begin
        if (!FRAME) begin
          state_d   = ST_BUSY;
          owner_d   = PARK;
          grantee_d = PARK;
          rel_d     = others(req, PARK);
        end else if (any_req && winner == PARK) begin
          state_d   = ST_GRANT;
          grantee_d = PARK;
        end else if (any_req) begin
          state_d = ST_DEAD;
        end
      end
      ST_GRANT: begin
        if (!FRAME) begin
          state_d = ST_BUSY;
          owner_d = grantee;
          rel_d   = others(req, grantee);
        end else if (!req[grantee] || expired) begin
          state_d = ST_DEAD;
          owner_d = grantee;
        end else begin
          timer_d = idle ? timer + 1'b1 : timer;
        end
      end
      ST_BUSY: begin
        if (!idle) begin
          rel_d = rel | others(req, OWNER);
        end else if (rel) begin
          // release clocks already provided the all-high gap
          if (any_req) begin
            state_d   = ST_GRANT;
            grantee_d = winner;
          end else begin
            state_d = ST_PARK;
          end
        end else if (others(req, OWNER)) begin
          state_d = ST_DEAD;
        end else if (req[OWNER]) begin
          state_d   = ST_GRANT;
          grantee_d = OWNER;
        end else if (OWNER == PARK) begin
          state_d = ST_PARK;
        end else begin
          state_d = ST_DEAD;
        end
      end
      default: state_d = ST_DEAD;
    endcase
  end

  always_comb begin
    gnt_d = '1;
    unique case (state_d)
      ST_PARK:  gnt_d[PARK] = 1'b0;
      ST_GRANT: gnt_d[grantee_d] = 1'b0;
      ST_BUSY:  if (!rel_d) gnt_d[owner_d] = 1'b0;
      default:  gnt_d = '1;
    endcase
  end

endmodule

// File: tb/tb_pci_arbiter.sv
// Directed bench for pci_arbiter with N=4, park master 0, timeout 16.
// Expected GNT/OWNER values are hand-derived per scenario.
module tb_pci_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FRAME;
  logic       IRDY;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] OWNER;
  logic       BUS_BUSY;

  int errors = 0;
  int checks = 0;

  pci_arbiter #(
    .N_MASTERS   (4),
    .PARK_MASTER (0),
    .GNT_TIMEOUT (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .FRAME    (FRAME),
    .IRDY     (IRDY),
    .REQ      (REQ),
    .GNT      (GNT),
    .OWNER    (OWNER),
    .BUS_BUSY (BUS_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    REQ   = 4'hF;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    RST   = 1'b0;
    #3;
    RST   = 1'b1;
    step();
  endtask

  int order [4] = '{0, 3, 0, 3};
  int nrec;
  int cnt;
  int m;
  logic gap;

  initial begin
    RST   = 1'b0;
    FRAME = 1'b1;
    IRDY  = 1'b1;
    REQ   = 4'hF;
    #12;
    chk("rst_gnt", GNT, 4'hF);
    chk("rst_owner", OWNER, 3);
    chk("rst_busy", BUS_BUSY, 0);
    RST = 1'b1;
    step();
    chk("park_gnt", GNT, 4'b1110);
    chk("park_owner", OWNER, 3);

    // idle bus, master 2 requests
    REQ = 4'b1011;
    step();
    chk("m2_dead", GNT, 4'b1111);
    step();
    chk("m2_grant", GNT, 4'b1011);
    chk("m2_grant_owner", OWNER, 3);
    FRAME = 1'b0;
    IRDY  = 1'b0;
    step();
    chk("m2_busy_gnt", GNT, 4'b1011);
    chk("m2_busy_owner", OWNER, 2);
    chk("m2_busy_flag", BUS_BUSY, 1);
    FRAME = 1'b1;
    REQ   = 4'hF;
    step();
    chk("m2_last_gnt", GNT, 4'b1011);
    IRDY = 1'b1;
    step();
    chk("m2_end_dead", GNT, 4'b1111);
    chk("m2_end_busy", BUS_BUSY, 0);
    step();
    chk("m2_end_park", GNT, 4'b1110);

    // fairness between masters 0 and 3
    do_reset();
    REQ  = 4'b0110;
    nrec = 0;
    cnt  = 0;
    gap  = 1'b0;
    for (int c = 0; c < 80 && nrec < 4; c++) begin
      step();
      chk("one_low", int'($countones(~GNT) <= 1), 1);
      if (GNT == 4'hF) gap = 1'b1;
      if (cnt == 0 && FRAME && IRDY && GNT != 4'hF) begin
        m = 0;
        for (int i = 0; i < 4; i++) if (!GNT[i]) m = i;
        chk("rr_order", m, order[nrec]);
        if (nrec > 0) chk("rr_gap", gap, 1);
        nrec++;
        gap   = 1'b0;
        cnt   = 4;
        FRAME = 1'b0;
        IRDY  = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 1) FRAME = 1'b1;
        if (cnt == 0) IRDY = 1'b1;
      end
    end
    chk("rr_count", nrec, 4);

    // hidden arbitration during master 1 transfer
    do_reset();
    REQ = 4'b1101;
    step();
    chk("hid_dead", GNT, 4'b1111);
    step();
    chk("hid_grant", GNT, 4'b1101);
    FRAME = 1'b0;
    IRDY  = 1'b0;
    step();
    chk("hid_busy", GNT, 4'b1101);
    step();
    REQ = 4'b1011;
    step();
    chk("hid_release", GNT, 4'b1111);
    step();
    chk("hid_hold", GNT, 4'b1111);
    FRAME = 1'b1;
    step();
    chk("hid_last", GNT, 4'b1111);
    IRDY = 1'b1;
    step();
    chk("hid_regrant", GNT, 4'b1011);
    chk("hid_owner", OWNER, 1);

    // timeout: master 2 owns, then 3 and 1 request
    do_reset();
    REQ = 4'b1011;
    step();
    step();
    FRAME = 1'b0;
    step();
    chk("to_pre_owner", OWNER, 2);
    FRAME = 1'b1;
    REQ   = 4'b0101;
    step();
    chk("to_dead", GNT, 4'b1111);
    step();
    chk("to_grant3", GNT, 4'b0111);
    for (int i = 0; i < 15; i++) step();
    chk("to_hold15", GNT, 4'b0111);
    step();
    chk("to_expire", GNT, 4'b1111);
    chk("to_owner", OWNER, 3);
    step();
    chk("to_next1", GNT, 4'b1101);
    REQ = 4'b0111;
    step();
    chk("to_drop1", GNT, 4'b1111);
    step();
    chk("to_grant3b", GNT, 4'b0111);
    for (int i = 0; i < 15; i++) step();
    chk("to_hold15b", GNT, 4'b0111);
    step();
    chk("to_expire_b", GNT, 4'b1111);
    step();
    chk("to_regrant3", GNT, 4'b0111);

    // park master request, then async reset mid-BUSY
    do_reset();
    REQ = 4'b1110;
    step();
    chk("pk_grant", GNT, 4'b1110);
    FRAME = 1'b0;
    IRDY  = 1'b0;
    step();
    chk("pk_busy_owner", OWNER, 0);
    chk("pk_busy_flag", BUS_BUSY, 1);
    #3;
    RST = 1'b0;
    #1;
    chk("ar_gnt", GNT, 4'hF);
    chk("ar_owner", OWNER, 3);
    chk("ar_busy", BUS_BUSY, 0);
    FRAME = 1'b1;
    IRDY  = 1'b1;
    REQ   = 4'hF;
    @(negedge CLK);
    RST = 1'b1;
    step();
    chk("ar_park", GNT, 4'b1110);
    chk("ar_park_owner", OWNER, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
